// File: rtl/cdm16_irq_ctrl.sv
// Purpose: prioritising interrupt controller for cdm16 (mask, edge/level, nested in-service, EOI).
// Latency: irq/int_vec combinational from registered state; edge requests pend one falling edge after the rising edge.
// Backpressure: none; a request is held until the core acks it or software masks/clears it.
module cdm16_irq_ctrl #(
    parameter int         N_SRC          = 8,
    parameter logic [5:0] RESET_VEC_BASE = 6'd16
) (
    input  logic             input_clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    output logic             irq,
    output logic [5:0]       int_vec,
    input  logic             iack,
    input  logic             cfg_sel,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    output logic [15:0]      cfg_rdata
);

    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edge_en;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] isr;
    logic [5:0]       vec_base;
    logic [N_SRC-1:0] src_q;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] edge_set;
    logic [3:0]       win;
    logic             win_vld;
    logic [3:0]       isr_top;
    logic             ack;
    logic [N_SRC-1:0] ack_set;
    logic [N_SRC-1:0] isr_low;
    logic             cfg_wr;
    logic             eoi;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] isr_nxt;

    // Effective requests: edge sources come from the pending latch, level sources straight from the sampled line.
    always_comb begin
        req      = mask & ((edge_en & pend) | (~edge_en & src_q));
        edge_set = edge_en & ~src_q & src;
    end

    // Priority encoders: lowest-index request wins; isr_top is N_SRC when nothing is in service.
    always_comb begin
        win     = 4'(N_SRC);
        win_vld = 1'b0;
        isr_top = 4'(N_SRC);
        isr_low = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win     = 4'(i);
                win_vld = 1'b1;
            end
            if (isr[i]) begin
                isr_top    = 4'(i);
                isr_low    = '0;
                isr_low[i] = 1'b1;
            end
        end
    end

    // Core-facing outputs: only strictly higher priority than the in-service level may interrupt.
    always_comb begin
        irq     = win_vld && (win < isr_top);
        int_vec = irq ? (vec_base + {2'b00, win}) : vec_base;
    end

    // Next-state for PEND and ISR: edge set beats clears; EOI clear is applied before the ack set.
    always_comb begin
        cfg_wr  = cfg_sel && cfg_we;
        eoi     = cfg_wr && (cfg_addr == 2'd3) && cfg_wdata[15];
        ack     = iack && irq;
        ack_set = '0;
        w1c     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_set[i] = ack && (win == 4'(i));
            w1c[i]     = cfg_wr && (cfg_addr == 2'd2) && cfg_wdata[i];
        end
        pend_nxt = (pend & ~w1c & ~(ack_set & edge_en)) | edge_set;
        isr_nxt  = (isr & ~(eoi ? isr_low : '0)) | ack_set;
    end

    // State registers update on the falling edge, shared with the core.
    always_ff @(negedge input_clock) begin
        if (reset) begin
            mask     <= '0;
            edge_en  <= '0;
            pend     <= '0;
            isr      <= '0;
            vec_base <= RESET_VEC_BASE;
            src_q    <= '0;
        end else begin
            src_q <= src;
            pend  <= pend_nxt;
            isr   <= isr_nxt;
            if (cfg_wr && (cfg_addr == 2'd0)) mask    <= cfg_wdata[N_SRC-1:0];
            if (cfg_wr && (cfg_addr == 2'd1)) edge_en <= cfg_wdata[N_SRC-1:0];
            if (cfg_wr && (cfg_addr == 2'd3)) vec_base <= cfg_wdata[5:0];
        end
    end

    // Register read mux; unused high bits read zero and the bus is quiet when not selected.
    always_comb begin
        cfg_rdata = '0;
        if (cfg_sel) begin
            case (cfg_addr)
                2'd0: for (int i = 0; i < N_SRC; i++) cfg_rdata[i] = mask[i];
                2'd1: for (int i = 0; i < N_SRC; i++) cfg_rdata[i] = edge_en[i];
                2'd2: for (int i = 0; i < N_SRC; i++) cfg_rdata[i] = pend[i];
                default: begin
                    cfg_rdata[5:0] = vec_base;
                    for (int i = 0; i < N_SRC; i++) cfg_rdata[8+i] = isr[i];
                end
            endcase
        end
    end

endmodule
